// File: rtl/fm_demod_pkg.sv
// rtl/fm_demod_pkg.sv - shared types and constants for the FM frequency estimator
package fm_demod_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int DEF_NBITS_PHASE  = 13;
    localparam int DEF_NBITS_WINDOW = 10;
    localparam int SHIFT            = DEF_NBITS_PHASE - DEF_NBITS_WINDOW;

    localparam logic signed [31:0] DEF_HYST = 32'sd4096;

endpackage

// File: rtl/zc_detect.sv
// rtl/zc_detect.sv - rising zero-crossing detector with symmetric hysteresis
module zc_detect
    import fm_demod_pkg::*;
#(
    parameter logic signed [31:0] HYST = DEF_HYST
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enableclk,
    input  logic               clear,
    input  logic signed [31:0] insine,
    output logic               armed,
    output logic               crossing
);

    logic is_low;
    logic is_high;

    assign is_low   = insine < -HYST;
    assign is_high  = insine >= HYST;
    assign crossing = armed & is_high;

    // Low and high thresholds are disjoint, so arming and firing never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (clear) begin
            armed <= 1'b0;
        end else if (enableclk) begin
            if (is_low) begin
                armed <= 1'b1;
            end else if (crossing) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fm_freq_estimator.sv
// rtl/fm_freq_estimator.sv - recovers phase increment by gated zero-crossing count
module fm_freq_estimator
    import fm_demod_pkg::*;
#(
    parameter int                 NBITS_PHASE  = DEF_NBITS_PHASE,
    parameter int                 NBITS_WINDOW = DEF_NBITS_WINDOW,
    parameter logic signed [31:0] HYST         = DEF_HYST
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enableclk,
    input  logic               clear,
    input  logic signed [31:0] insine,
    output logic [31:0]        phaseinc_est,
    output logic               est_valid,
    output logic               locked
);

    localparam int EST_SHIFT = NBITS_PHASE - NBITS_WINDOW;

    fsm_state_t              state;
    fsm_state_t              state_d;
    logic [NBITS_WINDOW-1:0] win_cnt;
    logic [NBITS_WINDOW-1:0] win_cnt_d;
    logic [NBITS_WINDOW-1:0] xcnt;
    logic [NBITS_WINDOW-1:0] xcnt_d;
    logic [NBITS_WINDOW:0]   final_cnt;
    logic [31:0]             est_d;
    logic                    window_end;
    logic                    sync_hit;
    logic                    armed;
    logic                    crossing;

    zc_detect #(
        .HYST (HYST)
    ) u_zc_detect (
        .clock     (clock),
        .reset     (reset),
        .enableclk (enableclk),
        .clear     (clear),
        .insine    (insine),
        .armed     (armed),
        .crossing  (crossing)
    );

    assign sync_hit  = insine < -HYST;
    // A crossing on the closing sample still belongs to the window being reported.
    assign final_cnt = {1'b0, xcnt} + {{NBITS_WINDOW{1'b0}}, crossing};
    assign est_d     = 32'(final_cnt) << EST_SHIFT;

    always_comb begin
        state_d    = state;
        win_cnt_d  = win_cnt;
        xcnt_d     = xcnt;
        window_end = 1'b0;
        case (state)
            SYNC: begin
                // The arming sample is sample 0, so the counter restarts at 1.
                if (sync_hit) begin
                    state_d   = RUN;
                    win_cnt_d = {{(NBITS_WINDOW-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                win_cnt_d = win_cnt + 1'b1;
                if (win_cnt == {NBITS_WINDOW{1'b1}}) begin
                    window_end = 1'b1;
                    xcnt_d     = '0;
                end else if (crossing) begin
                    xcnt_d = xcnt + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SYNC;
            win_cnt      <= '0;
            xcnt         <= '0;
            phaseinc_est <= '0;
            est_valid    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            est_valid <= 1'b0;
            if (clear) begin
                state   <= SYNC;
                win_cnt <= '0;
                xcnt    <= '0;
                locked  <= 1'b0;
            end else if (enableclk) begin
                state   <= state_d;
                win_cnt <= win_cnt_d;
                xcnt    <= xcnt_d;
                if (window_end) begin
                    phaseinc_est <= est_d;
                    est_valid    <= 1'b1;
                    locked       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_freq_estimator.sv
// tb/tb_fm_freq_estimator.sv - directed self-checking bench for fm_freq_estimator
module tb_fm_freq_estimator;

    logic               clock;
    logic               reset;
    logic               enableclk;
    logic               clear;
    logic signed [31:0] insine;
    logic [31:0]        phaseinc_est;
    logic               est_valid;
    logic               locked;

    int total = 0;
    int bad   = 0;

    int          cyc      = 0;
    int          nvalid   = 0;
    int          ndouble  = 0;
    int          last_vcyc = 0;
    int          prev_vcyc = 0;
    logic [31:0] last_est = 0;
    logic        prev_valid = 1'b0;

    int ph  = 0;
    int inc = 0;

    fm_freq_estimator dut (
        .clock        (clock),
        .reset        (reset),
        .enableclk    (enableclk),
        .clear        (clear),
        .insine       (insine),
        .phaseinc_est (phaseinc_est),
        .est_valid    (est_valid),
        .locked       (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (est_valid) begin
            nvalid    = nvalid + 1;
            last_est  = phaseinc_est;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            if (prev_valid) ndouble = ndouble + 1;
        end
        prev_valid = est_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] sine_of(input int p);
        real r;
        r = 1.0e6 * $sin(6.283185307179586 * real'(p % 8192) / 8192.0);
        return 32'($rtoi(r));
    endfunction

    task automatic drive(input logic signed [31:0] s, input logic en);
        insine    = s;
        enableclk = en;
        @(posedge clock);
        #1;
    endtask

    task automatic gen(input int n);
        for (int i = 0; i < n; i++) begin
            drive(sine_of(ph), 1'b1);
            ph = ph + inc;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        enableclk = 1'b0;
        insine    = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int nv0;
        int rcyc;
        reset     = 1'b1;
        clear     = 1'b0;
        enableclk = 1'b0;
        insine    = 0;
        do_reset();
        chk("rst_est", phaseinc_est, 0);
        chk("rst_valid", {31'd0, est_valid}, 0);
        chk("rst_locked", {31'd0, locked}, 0);

        // phaseinc 64: sync on sample 65, window end on sample 1088
        ph = 0; inc = 64;
        gen(1088);
        chk("p64_prelock", {31'd0, locked}, 0);
        chk("p64_novalid", nvalid, 0);
        gen(1);
        chk("p64_valid", {31'd0, est_valid}, 1);
        chk("p64_est", phaseinc_est, 64);
        chk("p64_locked", {31'd0, locked}, 1);
        gen(1);
        chk("p64_pulse", {31'd0, est_valid}, 0);
        gen(1023);
        chk("p64_valid2", {31'd0, est_valid}, 1);
        chk("p64_est2", phaseinc_est, 64);

        // asynchronous reset 500 samples into a window
        gen(500);
        #2 reset = 1'b1;
        #1;
        chk("arst_est", phaseinc_est, 0);
        chk("arst_locked", {31'd0, locked}, 0);
        chk("arst_valid", {31'd0, est_valid}, 0);
        rcyc = cyc;
        #1 reset = 1'b0;
        nv0 = nvalid;
        for (int i = 0; i < 1300 && nvalid == nv0; i++) gen(1);
        chk("arst_one_valid", nvalid - nv0, 1);
        chk("arst_gap", {31'd0, (last_vcyc - rcyc >= 1024) && (last_vcyc - rcyc <= 1160)}, 1);
        chk("arst_est2", last_est, 64);

        // clear retains the estimate; clear takes priority over a syncing sample
        drive(-32'sd100000, 1'b0);
        clear = 1'b1;
        drive(-32'sd100000, 1'b1);
        clear = 1'b0;
        chk("clr_est", phaseinc_est, 64);
        chk("clr_locked", {31'd0, locked}, 0);
        nv0 = nvalid;
        for (int i = 0; i < 1023; i++) drive(-32'sd100000, 1'b1);
        chk("dc_novalid", nvalid - nv0, 0);
        drive(-32'sd100000, 1'b1);
        chk("dc_valid", {31'd0, est_valid}, 1);
        chk("dc_est", phaseinc_est, 0);
        chk("dc_locked", {31'd0, locked}, 1);

        // square wave inside the dead band never syncs
        do_reset();
        nv0 = nvalid;
        for (int i = 0; i < 2100; i++) drive((i % 2 == 0) ? 32'sd4095 : -32'sd4095, 1'b1);
        chk("sq_novalid", nvalid - nv0, 0);
        chk("sq_locked", {31'd0, locked}, 0);

        // phaseinc 128 with enableclk one cycle in four
        do_reset();
        ph = 0; inc = 128;
        nv0 = nvalid;
        for (int k = 0; k < 2084; k++) begin
            drive(sine_of(ph), 1'b0);
            drive(sine_of(ph), 1'b0);
            drive(sine_of(ph), 1'b0);
            drive(sine_of(ph), 1'b1);
            ph = ph + inc;
        end
        chk("p128_nvalid", nvalid - nv0, 2);
        chk("p128_est", last_est, 128);
        chk("p128_spacing", last_vcyc - prev_vcyc, 4096);

        // crossing on the closing sample, threshold edges, arm carried over the boundary
        do_reset();
        for (int i = 0; i < 3; i++) drive(-32'sd4096, 1'b1);
        drive(-32'sd4097, 1'b1);
        for (int i = 0; i < 1022; i++) drive(0, 1'b1);
        drive(32'sd4096, 1'b1);
        chk("edge_valid", {31'd0, est_valid}, 1);
        chk("edge_est", phaseinc_est, 8);
        drive(0, 1'b1);
        chk("edge_pulse", {31'd0, est_valid}, 0);
        for (int i = 0; i < 1022; i++) drive(0, 1'b1);
        drive(-32'sd5000, 1'b1);
        chk("edge_next_valid", {31'd0, est_valid}, 1);
        chk("edge_next_est", phaseinc_est, 0);
        drive(32'sd5000, 1'b1);
        for (int i = 0; i < 1023; i++) drive(0, 1'b1);
        chk("carry_valid", {31'd0, est_valid}, 1);
        chk("carry_est", phaseinc_est, 8);

        chk("no_double_pulse", ndouble, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
